// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between an instruction-fetch requester and a data requester,
// capping consecutive data grants while a fetch waits and aborting stuck accesses.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned MAX_DBURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    localparam logic [3:0] DMAX  = 4'(MAX_DBURST);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [3:0]        dcnt;
    logic [7:0]        tcnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              busy;

    assign busy    = (state == BUSY_I) || (state == BUSY_D);
    assign m_req   = busy;
    assign m_we    = busy & lat_we;
    assign m_addr  = busy ? lat_addr  : '0;
    assign m_wdata = busy ? lat_wdata : '0;
    assign stall   = (i_req & ~i_ack) | (d_req & ~d_ack);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            dcnt      <= '0;
            tcnt      <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    // Data wins unless it has used up its burst allowance while a fetch waits.
                    if (d_req && !(dcnt == DMAX && i_req)) begin
                        state     <= BUSY_D;
                        lat_we    <= d_we;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        if (!i_req)
                            dcnt <= '0;
                        else if (dcnt != DMAX)
                            dcnt <= dcnt + 4'd1;
                    end else if (i_req) begin
                        state     <= BUSY_I;
                        lat_we    <= 1'b0;
                        lat_addr  <= i_addr;
                        lat_wdata <= '0;
                        dcnt      <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A memory ack arriving on the last allowed cycle still counts as success.
                    if (m_ack) begin
                        if (state == BUSY_I) begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                            state   <= RESP_I;
                        end else begin
                            if (!lat_we)
                                d_rdata <= m_rdata;
                            d_ack <= 1'b1;
                            state <= RESP_D;
                        end
                    end else if (tcnt == TLAST) begin
                        err <= 1'b1;
                        if (state == BUSY_I) begin
                            i_rdata <= '0;
                            i_ack   <= 1'b1;
                            state   <= RESP_I;
                        end else begin
                            d_rdata <= '0;
                            d_ack   <= 1'b1;
                            state   <= RESP_D;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                RESP_I, RESP_D: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

endmodule
